// File: rtl/sort_topk_buffer.sv
// Streaming top-K collector: keeps the DEPTH best (value,index) pairs of a frame sorted, then drains them in rank order.
// Latency: one beat inserted per cycle; the first ranked entry is presented the cycle after the in_last beat is accepted.
// Backpressure: in_ready drops for the whole drain; the output holds steady while out_ready is low.
module sort_topk_buffer #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 32,
  parameter int DEPTH  = 8,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in,
  input  logic        [IDX_W-1:0]  index,
  input  logic                     in_last,
  input  logic                     asce,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] value_out,
  output logic        [IDX_W-1:0]  value_index_out,
  output logic                     out_last,
  output logic        [CW-1:0]     count
);

  typedef enum logic {COLLECT, DRAIN} state_t;

  state_t                     state_q, state_d;
  logic signed [DATA_W-1:0]   val_q [DEPTH];
  logic signed [DATA_W-1:0]   val_d [DEPTH];
  logic        [IDX_W-1:0]    idx_q [DEPTH];
  logic        [IDX_W-1:0]    idx_d [DEPTH];
  logic        [CW-1:0]       count_q, count_d, rd_q, rd_d;
  logic                       mode_q, mode_d;
  logic                       in_ready_q, in_ready_d;
  logic                       out_valid_q, out_valid_d;
  logic                       out_last_q, out_last_d;
  logic signed [DATA_W-1:0]   vout_q, vout_d;
  logic        [IDX_W-1:0]    iout_q, iout_d;

  logic                       accept, hs, eff_mode;
  logic        [DEPTH-1:0]    prec;
  logic signed [DATA_W-1:0]   ins_val [DEPTH];
  logic        [IDX_W-1:0]    ins_idx [DEPTH];
  logic        [CW-1:0]       rd_nxt;
  logic signed [DATA_W-1:0]   rd_val;
  logic        [IDX_W-1:0]    rd_idx;

  assign accept   = in_ready_q & in_valid;
  assign hs       = out_valid_q & out_ready;
  // The first beat of a frame uses the live asce; later beats use the latched mode.
  assign eff_mode = (count_q == '0) ? asce : mode_q;

  // Parallel compare: prec is a prefix mask of held entries ranking ahead of the new beat (ties stay ahead for stability).
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      prec[i] = 1'b0;
      if (CW'(i) < count_q)
        prec[i] = eff_mode ? (val_q[i] <= in) : (val_q[i] >= in);
    end
    ins_val[0] = prec[0] ? val_q[0] : in;
    ins_idx[0] = prec[0] ? idx_q[0] : index;
    for (int i = 1; i < DEPTH; i++) begin
      if (prec[i]) begin
        ins_val[i] = val_q[i];
        ins_idx[i] = idx_q[i];
      end else if (prec[i-1]) begin
        ins_val[i] = in;
        ins_idx[i] = index;
      end else begin
        ins_val[i] = val_q[i-1];
        ins_idx[i] = idx_q[i-1];
      end
    end
  end

  // Select the entry the drain pointer moves to next.
  always_comb begin
    rd_nxt = rd_q + 1'b1;
    rd_val = '0;
    rd_idx = '0;
    for (int j = 0; j < DEPTH; j++) begin
      if (CW'(j) == rd_nxt) begin
        rd_val = val_q[j];
        rd_idx = idx_q[j];
      end
    end
  end

  // Next-state and registered-output logic for the collect/drain FSM.
  always_comb begin
    state_d     = state_q;
    val_d       = val_q;
    idx_d       = idx_q;
    count_d     = count_q;
    rd_d        = rd_q;
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    vout_d      = vout_q;
    iout_d      = iout_q;
    case (state_q)
      COLLECT: begin
        if (accept) begin
          val_d = ins_val;
          idx_d = ins_idx;
          if (count_q == '0) mode_d = asce;
          if (count_q != CW'(DEPTH)) count_d = count_q + 1'b1;
          if (in_last) begin
            state_d     = DRAIN;
            rd_d        = '0;
            out_valid_d = 1'b1;
            vout_d      = ins_val[0];
            iout_d      = ins_idx[0];
            out_last_d  = (count_d == CW'(1));
          end
        end
      end
      DRAIN: begin
        if (hs) begin
          if (out_last_q) begin
            state_d     = COLLECT;
            count_d     = '0;
            rd_d        = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            vout_d      = '0;
            iout_d      = '0;
          end else begin
            rd_d       = rd_nxt;
            vout_d     = rd_val;
            iout_d     = rd_idx;
            out_last_d = (rd_nxt == count_q - 1'b1);
          end
        end
      end
      default: state_d = COLLECT;
    endcase
    in_ready_d = (state_d == COLLECT);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= COLLECT;
      count_q     <= '0;
      rd_q        <= '0;
      mode_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      vout_q      <= '0;
      iout_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        val_q[i] <= '0;
        idx_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_q        <= rd_d;
      mode_q      <= mode_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      vout_q      <= vout_d;
      iout_q      <= iout_d;
      val_q       <= val_d;
      idx_q       <= idx_d;
    end
  end

  assign in_ready        = in_ready_q;
  assign out_valid       = out_valid_q;
  assign out_last        = out_last_q;
  assign value_out       = vout_q;
  assign value_index_out = iout_q;
  assign count           = count_q;

endmodule

// File: doc/sort_topk_buffer.md
# sort_topk_buffer

Streaming top-K collector placed directly downstream of `sort_relu`. It accepts one (value, index) pair per cycle, keeps the DEPTH best entries of the current frame in a sorted register array (ascending or descending), and drains them in rank order over a valid/ready output once the frame's last beat arrives. The output feeds the result writeback path.

## Interface
- `DATA_W`, 32: value width; values are compared as signed two's complement.
- `IDX_W`, 32: index width.
- `DEPTH`, 8: number of retained entries (K), at least 2.

- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: block can accept a beat.
- `in` in DATA_W: input value.
- `index` in IDX_W: input index.
- `in_last` in 1: final beat of the frame.
- `asce` in 1: 1 keeps the DEPTH smallest, ascending; 0 keeps the DEPTH largest, descending.
- `out_valid` out 1: output entry valid.
- `out_ready` in 1: consumer accepts the entry.
- `value_out` out DATA_W: ranked value.
- `value_index_out` out IDX_W: index of the ranked value.
- `out_last` out 1: marks the final drained entry.
- `count` out $clog2(DEPTH+1): number of entries held.

## Operation
- Two states: COLLECT and DRAIN. Reset enters COLLECT with `count`=0.
- COLLECT:
  - `in_ready`=1, `out_valid`=0.
  - Accept happens when `in_valid` is high.
  - On the first accept of a frame (`count`=0), `asce` is latched into `mode`, which holds for the whole frame. Later changes to `asce` are ignored until the next frame.
- Insertion, one per cycle, parallel compare-and-shift:
  - Insertion position p is the number of held entries e that precede the new entry.
  - In ascending mode, e precedes when e.value <= new.
  - In descending mode, e precedes when e.value >= new.
  - The sort is stable: for equal values, the earlier arrival ranks first.
  - If p < DEPTH: entries p..count-1 shift up one slot, the new entry is written at slot p, and `count` increments saturating at DEPTH. When the array was full, the old slot DEPTH-1 is discarded.
  - If p = DEPTH (array full): the beat is dropped and the array is unchanged.
- Accepting a beat with `in_last`=1 performs its insertion, then moves to DRAIN.
- DRAIN:
  - `in_ready`=0.
  - A read pointer r starts at 0. `value_out` and `value_index_out` show slot r, with `out_valid`=1.
  - `out_last`=1 when r = `count`-1.
  - A handshake (`out_valid` and `out_ready`) advances r.
  - The handshake with `out_last` returns the block to COLLECT with `count`=0 and r=0.
- `in_valid` is ignored when `in_ready`=0. Input beats offered during DRAIN are not consumed, so the upstream stage must hold them.
- Every frame contains at least one beat, because `in_last` is itself a beat. Empty frames do not exist.

## Timing
- Reset values: `in_ready`=0 during the reset cycle and 1 from the first cycle after reset. `out_valid`=0, `out_last`=0, `value_out`=0, `value_index_out`=0, `count`=0. The array is cleared to 0.
- Reset asserted mid-frame or mid-drain discards all state on the next edge. There is no partial output.
- Input throughput: 1 beat per cycle in COLLECT, with no bubbles.
- Latency: if the `in_last` beat is accepted at edge t, then `out_valid`=1 with rank 0 from edge t (the cycle after acceptance). `in_ready`=0 in that same cycle.
- Output: 1 entry per cycle while `out_ready`=1. While `out_ready`=0, `value_out`, `value_index_out` and `out_last` hold stable.
- Return to COLLECT: `in_ready`=1 in the cycle after the `out_last` handshake. A frame of n held entries with no backpressure occupies exactly n DRAIN cycles.
- `count` updates on the edge of each accept and reads 0 in the cycle after the final drain handshake.
- All outputs are registered. `in_ready` is derived from the state register only.

## Test plan
- Ascending, DEPTH=4:
  - Stimulus: values 20,15,25,5,2,10,35 with indices 0..6, `in_last` on the beat of 35, `out_ready`=1.
  - Required response: drained (2,4),(5,3),(10,5),(15,1), with `out_last` on the 4th entry. `out_valid` rises the cycle after the last input.
- Descending, DEPTH=4:
  - Stimulus: values 13,11,7,15,8,12,9 with indices 7..13, `asce`=0.
  - Required response: (15,10),(13,7),(12,12),(11,8).
- Stability and short frame, DEPTH=8:
  - Stimulus: (5,0),(5,1),(3,2) in ascending mode, with `in_last` on the 3rd beat.
  - Required response: (3,2),(5,0),(5,1), with `count`=3 and `out_last` on the 3rd entry.
- Backpressure:
  - Stimulus: drain with `out_ready` toggling 1,0,0,1.
  - Required response: entries never skip or repeat, outputs stay stable while stalled, and `in_ready` stays 0 until after the `out_last` handshake.
- Mode latch and single beat:
  - Stimulus: `asce` flipped mid-frame.
  - Required response: ordering still follows the value latched at the first beat.
  - Stimulus: a one-beat frame (-7,42) with `in_last`.
  - Required response: a single (-7,42) entry with `out_last`=1.
- Reset mid-drain:
  - Stimulus: `rst`=0 during DRAIN after 2 handshakes.
  - Required response: on the next edge, `out_valid`=0 and `count`=0. In the following cycle `in_ready`=1, and a new frame drains correctly with no stale entries.
